// File: rtl/prod_accumulator_if.sv
// Handshake bundle between a product source and prod_accumulator.
//   in_valid/in_ready/in_prod/len : product stream plus frame length of the first beat
//   out_valid/out_ready/out_sum/out_count : held frame-result handshake
// Modports: master = product source / result consumer, slave = accumulator.
interface prod_accumulator_if #(
  parameter int unsigned PW    = 7,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned AW    = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_prod;
  logic [CNT_W-1:0] len;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_sum;
  logic [CNT_W:0]   out_count;

  modport master (
    output in_valid, in_prod, len, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_prod, len, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums a frame of `len` unsigned products (len==0 means 2^CNT_W)
// and presents the total on a held output handshake.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   clear - synchronous frame abort (drops partial sum and pending result)
//   bus   - prod_accumulator_if.slave: product input and frame-result output
//   busy  - frame in progress (state != IDLE)
//   ovf   - sticky saturation flag
// Optional build macro ACC_SAT_EN: saturate the accumulator at 2^AW-1 and set ovf;
// without it the add wraps modulo 2^AW and ovf stays 0.
module prod_accumulator #(
  parameter int unsigned PW    = 7,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned AW    = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  prod_accumulator_if.slave bus,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned CW = CNT_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    state, state_n;
  logic [AW-1:0] acc, acc_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] len_q, len_q_n;
  logic          out_valid_q, out_valid_n;
  logic [AW-1:0] out_sum_q, out_sum_n;
  logic [CW-1:0] out_count_q, out_count_n;
  logic          busy_q, busy_n;
  logic          ovf_q, ovf_n;

  logic          xfer;
  logic [AW-1:0] add_base;
  logic [AW-1:0] add_res;
  logic          add_ovf;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] len_res;

  // Ready depends only on state and clear, never on in_valid.
  assign bus.in_ready  = (state != ST_HOLD) && !clear;
  assign xfer          = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign busy          = busy_q;
  assign ovf           = ovf_q;

  // Accumulator adder; the first product of a frame is added to zero.
`ifdef ACC_SAT_EN
  logic [AW:0] sum_wide;

  always_comb begin
    add_base = (state == ST_IDLE) ? '0 : acc;
    sum_wide = {1'b0, add_base} + (AW+1)'(bus.in_prod);
    add_ovf  = sum_wide[AW];
    add_res  = add_ovf ? '1 : sum_wide[AW-1:0];
  end
`else
  always_comb begin
    add_base = (state == ST_IDLE) ? '0 : acc;
    add_ovf  = 1'b0;
    add_res  = add_base + AW'(bus.in_prod);
  end
`endif

  // Next-state and datapath update.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    len_q_n     = len_q;
    out_valid_n = out_valid_q;
    out_sum_n   = out_sum_q;
    out_count_n = out_count_q;
    ovf_n       = ovf_q;
    cnt_inc     = cnt + CW'(1);
    len_res     = (bus.len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, bus.len};

    if (clear) begin
      state_n     = ST_IDLE;
      acc_n       = '0;
      cnt_n       = '0;
      len_q_n     = '0;
      out_valid_n = 1'b0;
      out_sum_n   = '0;
      out_count_n = '0;
      ovf_n       = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            acc_n   = add_res;
            cnt_n   = CW'(1);
            len_q_n = len_res;
            ovf_n   = ovf_q | add_ovf;
            if (len_res == CW'(1)) begin
              state_n     = ST_HOLD;
              out_valid_n = 1'b1;
              out_sum_n   = add_res;
              out_count_n = CW'(1);
            end else begin
              state_n = ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (xfer) begin
            acc_n = add_res;
            cnt_n = cnt_inc;
            ovf_n = ovf_q | add_ovf;
            if (cnt_inc == len_q) begin
              state_n     = ST_HOLD;
              out_valid_n = 1'b1;
              out_sum_n   = add_res;
              out_count_n = cnt_inc;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_n     = ST_IDLE;
            acc_n       = '0;
            cnt_n       = '0;
            out_valid_n = 1'b0;
            out_sum_n   = '0;
            out_count_n = '0;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end

    busy_n = (state_n != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      acc         <= '0;
      cnt         <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      cnt         <= cnt_n;
      len_q       <= len_q_n;
      out_valid_q <= out_valid_n;
      out_sum_q   <= out_sum_n;
      out_count_q <= out_count_n;
      busy_q      <= busy_n;
      ovf_q       <= ovf_n;
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Testbench for prod_accumulator: directed frames on a default-width instance checked
// every cycle against a frame-level model, plus an AW=8 instance for the overflow case.
module tb_prod_accumulator;

  localparam int unsigned PW    = 7;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned AW    = 11;

  logic clk;
  logic reset;
  logic clear;
  logic busy;
  logic ovf;
  logic clear8;
  logic busy8;
  logic ovf8;

  int n_checks;
  int n_fail;
  bit chk_en;

  prod_accumulator_if #(.PW(PW), .CNT_W(CNT_W), .AW(AW)) bus ();
  prod_accumulator_if #(.PW(PW), .CNT_W(CNT_W), .AW(8))  bus8 ();

  prod_accumulator #(.PW(PW), .CNT_W(CNT_W), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus),
    .busy  (busy),
    .ovf   (ovf)
  );

  prod_accumulator #(.PW(PW), .CNT_W(CNT_W), .AW(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .clear (clear8),
    .bus   (bus8),
    .busy  (busy8),
    .ovf   (ovf8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: running sum/count of accepted products and one pending result.
  int m_sum, m_n, m_target, m_osum, m_ocnt;
  bit m_pend, m_ovf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sum = 0; m_n = 0; m_target = 0; m_osum = 0; m_ocnt = 0; m_pend = 0; m_ovf = 0;
    end else if (clear) begin
      m_sum = 0; m_n = 0; m_target = 0; m_pend = 0; m_ovf = 0;
    end else if (m_pend) begin
      if (bus.out_ready) m_pend = 0;
    end else if (bus.in_valid) begin
      if (m_n == 0) m_target = (bus.len == 0) ? (1 << CNT_W) : int'(bus.len);
      m_sum = m_sum + int'(bus.in_prod);
`ifdef ACC_SAT_EN
      if (m_sum >= (1 << AW)) begin
        m_sum = (1 << AW) - 1;
        m_ovf = 1;
      end
`else
      m_sum = m_sum % (1 << AW);
`endif
      m_n++;
      if (m_n == m_target) begin
        m_pend = 1; m_osum = m_sum; m_ocnt = m_n; m_sum = 0; m_n = 0;
      end
    end
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("in_ready",  32'(bus.in_ready),  32'(!m_pend && !clear));
      check("out_valid", 32'(bus.out_valid), 32'(m_pend));
      if (m_pend) begin
        check("out_sum",   32'(bus.out_sum),   32'(m_osum));
        check("out_count", 32'(bus.out_count), 32'(m_ocnt));
      end
      check("busy", 32'(busy), 32'((m_n > 0) || m_pend));
      check("ovf",  32'(ovf),  32'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int l);
    bus.in_valid = 1'b1;
    bus.in_prod  = PW'(p);
    bus.len      = CNT_W'(l);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 0;
    reset = 1'b0; clear = 1'b0; clear8 = 1'b0;
    bus.in_valid = 1'b0; bus.in_prod = '0; bus.len = '0; bus.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_prod = '0; bus8.len = '0; bus8.out_ready = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_sum",   32'(bus.out_sum),   0);
    check("rst_out_count", 32'(bus.out_count), 0);
    check("rst_busy",      32'(busy),          0);
    check("rst_ovf",       32'(ovf),           0);
    check("rst_in_ready",  32'(bus.in_ready),  1);
    chk_en = 1;
    step();

    // len=4, consecutive products; result visible right after the 4th accept
    send(28, 4); send(40, 4); send(84, 4); send(55, 4);
    check("t1_valid", 32'(bus.out_valid), 1);
    check("t1_sum",   32'(bus.out_sum),   207);
    check("t1_count", 32'(bus.out_count), 4);
    bus.in_valid = 1'b1; bus.in_prod = 7'd7;
    step(); step();
    check("t1_ready_hold", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    handoff();
    step();

    // len=0 (16 products), valid toggled every other cycle
    for (int i = 0; i < 16; i++) begin
      send(105, 0);
      if (i != 15) step();
    end
    check("t2_sum",   32'(bus.out_sum),   1680);
    check("t2_count", 32'(bus.out_count), 16);
    handoff();
    step();

    // len=1, result held for 6 cycles, next product only after the IDLE bubble
    send(30, 1);
    bus.in_valid = 1'b1; bus.in_prod = 7'd50;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_sum",   32'(bus.out_sum),   30);
      check("t3_hold_valid", 32'(bus.out_valid), 1);
      step();
    end
    bus.out_ready = 1'b1;
    check("t3_last_sum", 32'(bus.out_sum), 30);
    step();
    bus.out_ready = 1'b0;
    check("t3_drop", 32'(bus.out_valid), 0);
    step();
    bus.in_valid = 1'b0;
    check("t3_next_sum",   32'(bus.out_sum),   50);
    check("t3_next_count", 32'(bus.out_count), 1);
    handoff();
    step();

    // clear with in_valid mid-frame, then a fresh len=2 frame
    send(10, 3); send(20, 3);
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_prod = 7'd99;
    step();
    clear = 1'b0; bus.in_valid = 1'b0;
    check("t4_busy",  32'(busy),          0);
    check("t4_valid", 32'(bus.out_valid), 0);
    send(5, 2); send(6, 2);
    check("t4_sum",   32'(bus.out_sum),   11);
    check("t4_count", 32'(bus.out_count), 2);
    handoff();
    step();

    // async reset mid-frame
    send(1, 4); send(2, 4);
    check("t5a_busy_before", 32'(busy), 1);
    #3 reset = 1'b1;
    #1;
    check("t5a_busy",  32'(busy),          0);
    check("t5a_valid", 32'(bus.out_valid), 0);
    check("t5a_sum",   32'(bus.out_sum),   0);
    @(posedge clk);
    #3 reset = 1'b0;
    step();

    // async reset while holding a result
    send(77, 1);
    check("t5b_valid_before", 32'(bus.out_valid), 1);
    #3 reset = 1'b1;
    #1;
    check("t5b_valid", 32'(bus.out_valid), 0);
    check("t5b_sum",   32'(bus.out_sum),   0);
    check("t5b_busy",  32'(busy),          0);
    @(posedge clk);
    #3 reset = 1'b0;
    step();

    // narrow accumulator: 4 x 84 = 336 exceeds 8 bits
    for (int i = 0; i < 4; i++) begin
      bus8.in_valid = 1'b1; bus8.in_prod = 7'd84; bus8.len = 4'd4;
      step();
    end
    bus8.in_valid = 1'b0;
    check("t6_valid", 32'(bus8.out_valid), 1);
    check("t6_count", 32'(bus8.out_count), 4);
`ifdef ACC_SAT_EN
    check("t6_sum", 32'(bus8.out_sum), 255);
    check("t6_ovf", 32'(ovf8),         1);
`else
    check("t6_sum", 32'(bus8.out_sum), 80);
    check("t6_ovf", 32'(ovf8),         0);
`endif
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    check("t6_drop", 32'(bus8.out_valid), 0);
    check("t6_busy", 32'(busy8),          0);
    step();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
Downstream consumer of the nXm_mul product stream. Accepts one PW-bit unsigned product per valid/ready handshake and sums a frame of `len` products. Presents the frame total on a held output handshake, which makes it the accumulate half of a multiply-accumulate path. Single clock domain; holds one frame at a time with no internal buffering beyond the accumulator.

Parameters:
PW, 7, product input width (4x3 multiplier output)
CNT_W, 4, frame-length field width; max frame = 2^CNT_W products
AW, 11, accumulator/output width; default PW+CNT_W cannot overflow

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
clear  in  1  synchronous frame abort
in_valid  in  1  product available
in_ready  out  1  block can accept a product this cycle
in_prod  in  PW  unsigned product
len  in  CNT_W  frame length, sampled with the first product of a frame; 0 means 2^CNT_W
out_valid  out  1  frame sum available
out_ready  in  1  consumer takes the sum
out_sum  out  AW  frame sum
out_count  out  CNT_W+1  number of products in the emitted frame
busy  out  1  frame in progress (state != IDLE)
ovf  out  1  sticky overflow flag (ACC_SAT_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, active-high) forces: state=IDLE, acc=0, cnt=0, len_q=0, out_valid=0, out_sum=0, out_count=0, busy=0, ovf=0. in_ready=1 once reset deasserts.
- A transfer occurs on a rising edge with in_valid && in_ready. Output is handed off on out_valid && out_ready.
- FSM states: IDLE, ACC, HOLD.
  - IDLE: in_ready=1. On transfer: acc<=in_prod, cnt<=1, len_q<=(len==0 ? 2^CNT_W : len). Go to HOLD if len_q resolves to 1, else to ACC.
  - ACC: in_ready=1. On transfer: acc<=acc+in_prod, cnt<=cnt+1. Go to HOLD when cnt+1==len_q. No transfer leaves everything unchanged; gaps in in_valid are allowed.
  - HOLD: in_ready=0, out_valid=1, out_sum=acc, out_count=cnt. All three stay stable until out_ready. On out_ready, go to IDLE and deassert out_valid next cycle; acc and cnt clear.
- Latency: out_valid rises on the clock edge that accepts the last product, so it is visible the cycle after that transfer.
- Back-to-back frames: the first product of the next frame is accepted no earlier than the cycle after the HOLD handoff (IDLE cycle). Minimum spacing is 1 bubble.
- in_ready is combinational from state and clear only; it never depends on in_valid.
- clear (sync): in_ready=0 while clear=1. On the edge it goes to IDLE, clears acc, cnt and out_valid, and drops any pending output. clear together with in_valid means the product is not accepted. clear takes priority over out_ready.
- len changes mid-frame are ignored; only len_q is used.
- Arithmetic: unsigned; in_prod is zero-extended to AW before the add.
- Reset mid-frame or in HOLD: immediate return to reset values; the partial sum is lost.

Optional Feature:
ACC_SAT_EN — when defined, an add whose true result is >= 2^AW saturates acc to 2^AW-1 and sets ovf. ovf is sticky and clears only on reset or clear. Once saturated, acc stays at the max value for the rest of the frame. When undefined, the add wraps modulo 2^AW and ovf is constant 0. This only matters when AW is overridden below PW+CNT_W.

Test Plan:
- Defaults, len=4, products 28,40,84,55 (14*2,10*4,12*7,11*5) on consecutive cycles -> out_valid the cycle after the 4th accept; out_sum=207, out_count=4; in_ready=0 until out_ready.
- len=0, 16 products of 105 with in_valid toggled every other cycle -> out_sum=1680, out_count=16; no products lost across the gaps.
- len=1, product 30, out_ready held low 5 cycles then high -> out_sum=30 is stable all 6 cycles. out_valid drops the next cycle; the next product is accepted no earlier than the cycle after that.
- len=3, two products accepted, then clear pulsed together with in_valid (product 99) -> 99 is not accepted; state IDLE, busy=0. A new len=2 frame of 5,6 gives out_sum=11.
- reset asserted asynchronously mid-ACC and in HOLD (between clock edges) -> out_valid, out_sum and busy go to 0 without waiting for a clock edge.
- AW=8, len=4, products 84 each: with ACC_SAT_EN -> out_sum=255, ovf=1; without it -> out_sum=80 (336 mod 256), ovf=0.
